// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU sequencer: operand source codes, ALU op codes,
// RV32I opcode/funct3 values, FSM state encoding and the EXEC-state select decoder.
package alu_ctrl_pkg;

  localparam logic [2:0] SRC_ZERO  = 3'd0;
  localparam logic [2:0] SRC_PC    = 3'd1;
  localparam logic [2:0] SRC_IMM7  = 3'd2;
  localparam logic [2:0] SRC_IMM12 = 3'd3;
  localparam logic [2:0] SRC_IMM20 = 3'd4;
  localparam logic [2:0] SRC_BOFF  = 3'd5;
  localparam logic [2:0] SRC_JOFF  = 3'd6;
  localparam logic [2:0] SRC_REG   = 3'd7;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EXEC     = 2'd1;
  localparam logic [1:0] ST_BR_TGT   = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT = 2'd3;

  typedef struct packed {
    logic [2:0] a_src;
    logic [2:0] b_src;
    logic [3:0] op;
  } alu_sel_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] arith_op(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] branch_op(input logic [2:0] funct3);
    if (!funct3[2]) return ALU_SUB;
    return funct3[1] ? ALU_SLTU : ALU_SLT;
  endfunction

  function automatic alu_sel_t exec_sel(input logic [6:0] opcode, input logic [2:0] funct3,
                                        input logic bit30);
    alu_sel_t s;
    s = '{SRC_ZERO, SRC_ZERO, ALU_ADD};
    case (opcode)
      OPC_OP:     s = '{SRC_REG, SRC_REG, arith_op(funct3, bit30)};
      OPC_OP_IMM: s = '{SRC_REG, SRC_IMM12, arith_op(funct3, bit30 && (funct3 == F3_SR))};
      OPC_LUI:    s = '{SRC_ZERO, SRC_IMM20, ALU_ADD};
      OPC_AUIPC:  s = '{SRC_PC, SRC_IMM20, ALU_ADD};
      OPC_JAL:    s = '{SRC_PC, SRC_JOFF, ALU_ADD};
      OPC_JALR:   s = '{SRC_REG, SRC_IMM12, ALU_ADD};
      OPC_BRANCH: s = '{SRC_REG, SRC_REG, branch_op(funct3)};
      OPC_LOAD:   s = '{SRC_REG, SRC_IMM12, ALU_ADD};
      OPC_STORE:  s = '{SRC_REG, SRC_ZERO, ALU_ADD};
      default:    s = '{SRC_ZERO, SRC_ZERO, ALU_ADD};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch decision from funct3 and the ALU flags; EQ/NE use the zero flag,
// LT/GE (signed and unsigned) use bit 0 of the SLT/SLTU result.
module branch_cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lsb,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_zero;
      F3_BNE:  taken = !alu_zero;
      F3_BLT:  taken = alu_lsb;
      F3_BGE:  taken = !alu_lsb;
      F3_BLTU: taken = alu_lsb;
      F3_BGEU: taken = !alu_lsb;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for the shared ALU: operand selects, PC/regfile/memory sequencing.
// Optional performance counters are built when ALU_SEQ_PERF_EN is defined.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned ALU_OP_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic [2:0]          alu_a_src,
  output logic [2:0]          alu_b_src,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic                alu_zero,
  input  logic                alu_lsb,
  output logic                rd_we,
  output logic                pc_load,
  output logic                pc_inc,
  output logic                mem_req,
  output logic                mem_we,
  input  logic                mem_ack,
`ifdef ALU_SEQ_PERF_EN
  output logic [31:0]         perf_retired,
  output logic [31:0]         perf_stall,
`endif
  output logic                illegal,
  output logic                busy
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [6:0] opcode_q;
  logic [2:0] funct3_q;
  alu_sel_t   sel_q, sel_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       br_taken;

  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  branch_cond_eval u_branch_cond_eval (
    .funct3   (funct3_q),
    .alu_zero (alu_zero),
    .alu_lsb  (alu_lsb),
    .taken    (br_taken)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mem_we_d  = mem_we_q;
    tmo_cnt_d = tmo_cnt_q;
    rd_we     = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_EXEC;
          sel_d   = exec_sel(instr[6:0], instr[14:12], instr[30]);
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        case (opcode_q)
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
            rd_we  = 1'b1;
            pc_inc = 1'b1;
          end
          OPC_JAL, OPC_JALR: pc_load = 1'b1;
          OPC_BRANCH: begin
            if (br_taken) begin
              state_d = ST_BR_TGT;
              sel_d   = '{SRC_PC, SRC_BOFF, ALU_ADD};
            end else begin
              pc_inc = 1'b1;
            end
          end
          OPC_LOAD, OPC_STORE: begin
            // address selects stay up for the whole memory wait
            state_d   = ST_MEM_WAIT;
            sel_d     = sel_q;
            mem_we_d  = (opcode_q == OPC_STORE);
            tmo_cnt_d = '0;
          end
          default: begin
            illegal = 1'b1;
            pc_inc  = 1'b1;
          end
        endcase
      end
      ST_BR_TGT: begin
        pc_load = 1'b1;
        state_d = ST_IDLE;
        sel_d   = '0;
      end
      ST_MEM_WAIT: begin
        // ack takes priority over a timeout landing in the same cycle
        if (mem_ack || (tmo_cnt_q == TMO_LAST)) begin
          rd_we     = mem_ack && !mem_we_q;
          pc_inc    = mem_ack;
          illegal   = !mem_ack;
          state_d   = ST_IDLE;
          sel_d     = '0;
          mem_we_d  = 1'b0;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      funct3_q  <= '0;
      sel_q     <= '0;
      mem_we_q  <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mem_we_q  <= mem_we_d;
      tmo_cnt_q <= tmo_cnt_d;
      if (instr_valid && instr_ready) begin
        opcode_q <= instr[6:0];
        funct3_q <= instr[14:12];
      end
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign mem_req     = (state_q == ST_MEM_WAIT);
  assign mem_we      = mem_we_q;
  assign alu_a_src   = sel_q.a_src;
  assign alu_b_src   = sel_q.b_src;
  assign alu_op      = ALU_OP_W'(sel_q.op);

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_retired_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pc_load || pc_inc) perf_retired_q <= perf_retired_q + 32'd1;
      if (mem_req && !mem_ack) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer against a per-instruction expectation model.
module tb_alu_op_sequencer;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [2:0]  alu_a_src;
  logic [2:0]  alu_b_src;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        alu_lsb;
  logic        rd_we;
  logic        pc_load;
  logic        pc_inc;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        illegal;
  logic        busy;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_retired = 0;
  int exp_stall   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .MEM_TIMEOUT (TMO),
    .ALU_OP_W    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_a_src    (alu_a_src),
    .alu_b_src    (alu_b_src),
    .alu_op       (alu_op),
    .alu_zero     (alu_zero),
    .alu_lsb      (alu_lsb),
    .rd_we        (rd_we),
    .pc_load      (pc_load),
    .pc_inc       (pc_inc),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
`ifdef ALU_SEQ_PERF_EN
    .perf_retired (perf_retired),
    .perf_stall   (perf_stall),
`endif
    .illegal      (illegal),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every output in one comparison-friendly word
  function automatic logic [31:0] outs();
    return {10'd0, instr_ready, busy, alu_a_src, alu_b_src, alu_op,
            rd_we, pc_load, pc_inc, mem_req, mem_we, illegal, 4'd0};
  endfunction

  function automatic logic [31:0] pack(input bit rdy, input bit bsy, input int a, input int b,
                                       input int op, input bit rd, input bit ld, input bit inc,
                                       input bit req, input bit we, input bit ill);
    return {10'd0, rdy, bsy, a[2:0], b[2:0], op[3:0], rd, ld, inc, req, we, ill, 4'd0};
  endfunction

  function automatic int arith_model(input logic [2:0] f3, input bit alt);
    int tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int r = tbl[f3];
    if (alt && f3 == 3'd0) r = 1;
    if (alt && f3 == 3'd5) r = 7;
    return r;
  endfunction

  task automatic check_perf(input string tag);
`ifdef ALU_SEQ_PERF_EN
    check_eq({tag, "_retired"}, perf_retired, exp_retired);
    check_eq({tag, "_stall"}, perf_stall, exp_stall);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_idle"}, outs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // ack_dly: MEM_WAIT cycle index carrying mem_ack (>= TMO means never acked)
  task automatic run_instr(input string tag, input logic [31:0] ins, input bit z, input bit l,
                           input int ack_dly);
    logic [6:0] opc;
    logic [2:0] f3;
    int ea, eb, eop;
    bit e_rd, e_ld, e_inc, e_ill, taken, is_mem, is_st, cond;
    opc = ins[6:0];
    f3  = ins[14:12];
    ea = 0; eb = 0; eop = 0;
    e_rd = 0; e_ld = 0; e_inc = 0; e_ill = 0; taken = 0; is_mem = 0; is_st = 0;
    case (opc)
      7'b0110011: begin ea = 7; eb = 7; eop = arith_model(f3, ins[30]); e_rd = 1; e_inc = 1; end
      7'b0010011: begin
        ea = 7; eb = 3; eop = arith_model(f3, (f3 == 3'd5) && ins[30]); e_rd = 1; e_inc = 1;
      end
      7'b0110111: begin ea = 0; eb = 4; e_rd = 1; e_inc = 1; end
      7'b0010111: begin ea = 1; eb = 4; e_rd = 1; e_inc = 1; end
      7'b1101111: begin ea = 1; eb = 6; e_ld = 1; end
      7'b1100111: begin ea = 7; eb = 3; e_ld = 1; end
      7'b1100011: begin
        ea = 7; eb = 7;
        eop = !f3[2] ? 1 : (f3[1] ? 4 : 3);
        cond = f3[2] ? l : z;
        taken = cond ^ f3[0];
        e_inc = !taken;
      end
      7'b0000011: begin ea = 7; eb = 3; is_mem = 1; end
      7'b0100011: begin ea = 7; eb = 0; is_mem = 1; is_st = 1; end
      default:    begin e_ill = 1; e_inc = 1; end
    endcase

    @(negedge clk);
    check_idle(tag);
    instr_valid = 1'b1;
    instr       = ins;
    alu_zero    = z;
    alu_lsb     = l;
    mem_ack     = 1'($urandom);

    @(negedge clk);
    instr_valid = 1'($urandom);
    instr       = $urandom;
    mem_ack     = 1'($urandom);
    #1;
    check_eq({tag, "_exec"}, outs(), pack(0, 1, ea, eb, eop, e_rd, e_ld, e_inc, 0, 0, e_ill));
    if (e_ld || e_inc) exp_retired++;

    if (taken) begin
      @(negedge clk);
      instr_valid = 1'($urandom);
      #1;
      check_eq({tag, "_brtgt"}, outs(), pack(0, 1, 1, 5, 0, 0, 1, 0, 0, 0, 0));
      exp_retired++;
    end

    if (is_mem) begin
      for (int k = 0; k < int'(TMO); k++) begin
        @(negedge clk);
        instr_valid = 1'($urandom);
        mem_ack     = (k == ack_dly);
        #1;
        if (k == ack_dly) begin
          check_eq({tag, "_ack"}, outs(), pack(0, 1, ea, eb, 0, !is_st, 0, 1, 1, is_st, 0));
          exp_retired++;
          break;
        end
        exp_stall++;
        check_eq({tag, "_wait"}, outs(),
                 pack(0, 1, ea, eb, 0, 0, 0, 0, 1, is_st, k == int'(TMO) - 1));
      end
    end
  endtask

  logic [6:0] opc_tbl[10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                              7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1110011};
  logic [6:0] bad_tbl[4]  = '{7'b1110011, 7'b0001111, 7'b1111111, 7'b0000000};
  logic [2:0] bf3_tbl[6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    logic [31:0] ins;
    int sel, dly;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    alu_zero = 1'b0; alu_lsb = 1'b0; mem_ack = 1'b0;
    #12;
    check_eq("reset", outs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_perf("reset");
    rst_n = 1'b1;

    run_instr("add", 32'h002081B3, 1'b0, 1'b0, 0);
    run_instr("sub", 32'h402081B3, 1'b0, 1'b0, 0);
    run_instr("srai", 32'h4030D193, 1'b0, 1'b0, 0);
    run_instr("beq_t", 32'h00208063, 1'b1, 1'b0, 0);
    run_instr("bne_nt", 32'h00209063, 1'b1, 1'b0, 0);
    run_instr("bltu_t", 32'h0020E063, 1'b0, 1'b1, 0);
    run_instr("lw", 32'h0000A183, 1'b0, 1'b0, 2);
    run_instr("sw_tmo", 32'h0030A023, 1'b0, 1'b0, 99);
    run_instr("sw_late", 32'h0030A023, 1'b0, 1'b0, int'(TMO) - 1);
    run_instr("ecall", 32'h00000073, 1'b0, 1'b0, 0);
    run_instr("jal", 32'h008000EF, 1'b0, 1'b0, 0);
    check_perf("directed");

    // Reset asserted while a load waits on memory
    @(negedge clk);
    check_idle("rst_pre");
    instr_valid = 1'b1; instr = 32'h0000A183; mem_ack = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_memwait", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid", outs(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_retired = 0; exp_stall = 0;
    check_perf("rst_mid");
    #2 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      ins = $urandom;
      ins[6:0] = opc_tbl[sel];
      if (sel == 9) ins[6:0] = bad_tbl[$urandom_range(0, 3)];
      if (sel == 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000;
      if (sel == 6) ins[14:12] = bf3_tbl[$urandom_range(0, 5)];
      dly = ($urandom_range(0, 3) == 0) ? 99 : $urandom_range(0, int'(TMO) - 1);
      run_instr("rand", ins, 1'($urandom), 1'($urandom), dly);
    end
    @(negedge clk);
    check_idle("final");
    check_perf("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
